// File: rtl/bounds_range_pkg.sv
// Shared types for the bounds range table: one table entry and the sweep FSM state.
// Entry address fields are RANGE_ADDR_W wide; the table's ADDR_W parameter must match.
package bounds_range_pkg;

  localparam int unsigned RANGE_ADDR_W = 32;

  typedef struct packed {
    logic                    valid;
    logic [RANGE_ADDR_W-1:0] base;
    logic [RANGE_ADDR_W-1:0] last;
  } range_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } tbl_state_e;

endpackage

// File: rtl/range_match.sv
// One lookup channel against every entry: hit vector, lowest hit index, overflow of the access end.
// Purely combinational (0 cycles); no handshake, the caller registers the result.
module range_match
  import bounds_range_pkg::*;
#(
  parameter int unsigned ADDR_W = RANGE_ADDR_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LEN_W  = 12,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  range_entry_t [DEPTH-1:0] i_tbl,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [LEN_W-1:0]         i_len,
  output logic [DEPTH-1:0]         o_hit_vec,
  output logic [IDX_W-1:0]         o_idx,
  output logic                     o_overflow
);

  localparam int unsigned EXT_W = ADDR_W + 1;

  logic [LEN_W-1:0]  w_len_eff;
  logic [EXT_W-1:0]  w_end;
  logic [ADDR_W-1:0] w_last_sel;

  // A zero-length access still touches one byte.
  assign w_len_eff = (i_len == '0) ? LEN_W'(1) : i_len;
  assign w_end     = {1'b0, i_addr} + EXT_W'(w_len_eff) - EXT_W'(1);

  always_comb begin
    o_hit_vec = '0;
    for (int j = 0; j < DEPTH; j++) begin
      o_hit_vec[j] = i_tbl[j].valid & (i_tbl[j].base <= i_addr) & (i_addr <= i_tbl[j].last);
    end
  end

  always_comb begin
    o_idx      = '0;
    w_last_sel = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (o_hit_vec[j]) begin
        o_idx      = IDX_W'(j);
        w_last_sel = i_tbl[j].last;
      end
    end
  end

  assign o_overflow = (|o_hit_vec) & (w_end[ADDR_W] | (w_end[ADDR_W-1:0] > w_last_sel));

endmodule

// File: rtl/bounds_range_table.sv
// Table of allocated [base,last] ranges with circular insert/evict, free-by-base and a DEPTH-cycle clear sweep.
// Lookups: 1-cycle latency, one per channel per cycle, never stalled; alloc is held off only by free or the sweep.
module bounds_range_table
  import bounds_range_pkg::*;
#(
  parameter int unsigned ADDR_W   = RANGE_ADDR_W,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned N_LOOKUP = 2,
  parameter int unsigned LEN_W    = 12,
  parameter int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               alloc_valid_i,
  output logic                               alloc_ready_o,
  input  logic [ADDR_W-1:0]                  alloc_base_i,
  input  logic [ADDR_W-1:0]                  alloc_last_i,
  input  logic                               free_valid_i,
  input  logic [ADDR_W-1:0]                  free_base_i,
  input  logic                               clear_i,
  input  logic [N_LOOKUP-1:0]                lk_valid_i,
  input  logic [N_LOOKUP-1:0][ADDR_W-1:0]    lk_addr_i,
  input  logic [N_LOOKUP-1:0][LEN_W-1:0]     lk_len_i,
  output logic [N_LOOKUP-1:0]                lk_valid_o,
  output logic [N_LOOKUP-1:0]                lk_hit_o,
  output logic [N_LOOKUP-1:0][IDX_W-1:0]     lk_idx_o,
  output logic [N_LOOKUP-1:0]                lk_overflow_o,
  output logic                               err_o,
  output logic                               evict_o,
  output logic [IDX_W:0]                     count_o,
  output logic                               busy_o
);

  localparam int unsigned CNT_W = IDX_W + 1;

  tbl_state_e                 r_state;
  range_entry_t [DEPTH-1:0]   r_tbl;
  logic [IDX_W-1:0]           r_wr_ptr;
  logic [IDX_W-1:0]           r_clr_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_err;
  logic                       r_evict;
  logic [N_LOOKUP-1:0]        r_lk_valid;
  logic [N_LOOKUP-1:0]        r_lk_hit;
  logic [N_LOOKUP-1:0][IDX_W-1:0] r_lk_idx;
  logic [N_LOOKUP-1:0]        r_lk_ov;

  logic [DEPTH-1:0]           w_overlap;
  logic [DEPTH-1:0]           w_free_hit;
  logic [CNT_W-1:0]           w_free_cnt;
  logic                       w_alloc_fire;
  logic                       w_alloc_bad;
  logic                       w_alloc_ok;
  logic                       w_free_fire;
  logic                       w_tgt_valid;

  logic [N_LOOKUP-1:0][DEPTH-1:0] w_hit_vec;
  logic [N_LOOKUP-1:0][IDX_W-1:0] w_idx;
  logic [N_LOOKUP-1:0]            w_ov;

  assign alloc_ready_o = (r_state == IDLE) & ~free_valid_i;
  assign w_alloc_fire  = alloc_valid_i & alloc_ready_o;
  assign w_free_fire   = free_valid_i & (r_state == IDLE);
  assign w_tgt_valid   = r_tbl[r_wr_ptr].valid;

  always_comb begin
    w_overlap  = '0;
    w_free_hit = '0;
    w_free_cnt = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_overlap[j]  = r_tbl[j].valid & (alloc_base_i <= r_tbl[j].last) & (r_tbl[j].base <= alloc_last_i);
      w_free_hit[j] = r_tbl[j].valid & (r_tbl[j].base == free_base_i);
      w_free_cnt    = w_free_cnt + CNT_W'(w_free_hit[j]);
    end
  end

  assign w_alloc_bad = (alloc_base_i > alloc_last_i) | (|w_overlap);
  assign w_alloc_ok  = w_alloc_fire & ~w_alloc_bad;

  for (genvar g = 0; g < N_LOOKUP; g++) begin : g_lk
    range_match #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .LEN_W  (LEN_W),
      .IDX_W  (IDX_W)
    ) u_match (
      .i_tbl      (r_tbl),
      .i_addr     (lk_addr_i[g]),
      .i_len      (lk_len_i[g]),
      .o_hit_vec  (w_hit_vec[g]),
      .o_idx      (w_idx[g]),
      .o_overflow (w_ov[g])
    );
  end

  // Lookups read the table as it stood before this cycle's update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lk_valid <= '0;
      r_lk_hit   <= '0;
      r_lk_idx   <= '0;
      r_lk_ov    <= '0;
    end else begin
      for (int i = 0; i < N_LOOKUP; i++) begin
        r_lk_valid[i] <= lk_valid_i[i];
        r_lk_hit[i]   <= lk_valid_i[i] & (|w_hit_vec[i]);
        r_lk_idx[i]   <= lk_valid_i[i] ? w_idx[i] : '0;
        r_lk_ov[i]    <= lk_valid_i[i] & w_ov[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_tbl     <= '0;
      r_wr_ptr  <= '0;
      r_clr_ptr <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_evict   <= 1'b0;
    end else begin
      r_err   <= w_alloc_fire & w_alloc_bad;
      r_evict <= w_alloc_ok & w_tgt_valid;
      case (r_state)
        IDLE: begin
          if (w_free_fire) begin
            for (int j = 0; j < DEPTH; j++) begin
              if (w_free_hit[j]) r_tbl[j].valid <= 1'b0;
            end
            r_count <= r_count - w_free_cnt;
          end else if (w_alloc_ok) begin
            r_tbl[r_wr_ptr] <= '{valid: 1'b1, base: alloc_base_i, last: alloc_last_i};
            r_wr_ptr        <= r_wr_ptr + IDX_W'(1);
            if (!w_tgt_valid) r_count <= r_count + CNT_W'(1);
          end
          if (clear_i) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
          end
        end
        CLEAR: begin
          r_tbl[r_clr_ptr] <= '0;
          if (r_clr_ptr == IDX_W'(DEPTH - 1)) begin
            r_state   <= IDLE;
            r_clr_ptr <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + IDX_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lk_valid_o    = r_lk_valid;
  assign lk_hit_o      = r_lk_hit;
  assign lk_idx_o      = r_lk_idx;
  assign lk_overflow_o = r_lk_ov;
  assign err_o         = r_err;
  assign evict_o       = r_evict;
  assign count_o       = r_count;
  assign busy_o        = (r_state == CLEAR);

endmodule

// File: tb/tb_bounds_range_table.sv
// Directed vector bench for bounds_range_table (DEPTH=8, two lookup channels).
module tb_bounds_range_table;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  alloc_valid_i;
  logic                  alloc_ready_o;
  logic [31:0]           alloc_base_i;
  logic [31:0]           alloc_last_i;
  logic                  free_valid_i;
  logic [31:0]           free_base_i;
  logic                  clear_i;
  logic [1:0]            lk_valid_i;
  logic [1:0][31:0]      lk_addr_i;
  logic [1:0][11:0]      lk_len_i;
  logic [1:0]            lk_valid_o;
  logic [1:0]            lk_hit_o;
  logic [1:0][2:0]       lk_idx_o;
  logic [1:0]            lk_overflow_o;
  logic                  err_o;
  logic                  evict_o;
  logic [3:0]            count_o;
  logic                  busy_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  bounds_range_table #(
    .ADDR_W(32), .DEPTH(8), .N_LOOKUP(2), .LEN_W(12)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_base_i(alloc_base_i), .alloc_last_i(alloc_last_i),
    .free_valid_i(free_valid_i), .free_base_i(free_base_i),
    .clear_i(clear_i),
    .lk_valid_i(lk_valid_i), .lk_addr_i(lk_addr_i), .lk_len_i(lk_len_i),
    .lk_valid_o(lk_valid_o), .lk_hit_o(lk_hit_o), .lk_idx_o(lk_idx_o),
    .lk_overflow_o(lk_overflow_o),
    .err_o(err_o), .evict_o(evict_o), .count_o(count_o), .busy_o(busy_o)
  );

  typedef struct {
    logic        a_v;
    logic [31:0] a_base;
    logic [31:0] a_last;
    logic        f_v;
    logic [31:0] f_base;
    logic        l_v    [2];
    logic [31:0] l_addr [2];
    logic [11:0] l_len  [2];
    logic        e_err;
    logic        e_evict;
    int          e_cnt;
    logic        e_hit  [2];
    int          e_idx  [2];
    logic        e_ov   [2];
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (row %0d): got %0h expected %0h", name, row, act, exp);
    end
  endtask

  function automatic vec_t v_none(input int cnt);
    vec_t v;
    v.a_v = 0; v.a_base = 0; v.a_last = 0; v.f_v = 0; v.f_base = 0;
    v.e_err = 0; v.e_evict = 0; v.e_cnt = cnt;
    for (int c = 0; c < 2; c++) begin
      v.l_v[c] = 0; v.l_addr[c] = 0; v.l_len[c] = 0;
      v.e_hit[c] = 0; v.e_idx[c] = 0; v.e_ov[c] = 0;
    end
    return v;
  endfunction

  function automatic vec_t v_alloc(input logic [31:0] b, input logic [31:0] l,
                                   input logic err, input logic ev, input int cnt);
    vec_t v = v_none(cnt);
    v.a_v = 1; v.a_base = b; v.a_last = l; v.e_err = err; v.e_evict = ev;
    return v;
  endfunction

  function automatic vec_t v_free(input logic [31:0] b, input int cnt);
    vec_t v = v_none(cnt);
    v.f_v = 1; v.f_base = b;
    return v;
  endfunction

  function automatic vec_t add_lk(input vec_t vi, input int c, input logic [31:0] addr,
                                  input logic [11:0] len, input logic hit, input int idx, input logic ov);
    vec_t v = vi;
    v.l_v[c] = 1; v.l_addr[c] = addr; v.l_len[c] = len;
    v.e_hit[c] = hit; v.e_idx[c] = idx; v.e_ov[c] = ov;
    return v;
  endfunction

  task automatic idle();
    alloc_valid_i = 0; alloc_base_i = 0; alloc_last_i = 0;
    free_valid_i = 0; free_base_i = 0; clear_i = 0;
    lk_valid_i = 0; lk_addr_i = '0; lk_len_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply(input vec_t v, input int row);
    alloc_valid_i = v.a_v; alloc_base_i = v.a_base; alloc_last_i = v.a_last;
    free_valid_i = v.f_v; free_base_i = v.f_base;
    for (int c = 0; c < 2; c++) begin
      lk_valid_i[c] = v.l_v[c]; lk_addr_i[c] = v.l_addr[c]; lk_len_i[c] = v.l_len[c];
    end
    #1;
    chk("alloc_ready", row, alloc_ready_o, !v.f_v);
    step();
    chk("err", row, err_o, v.e_err);
    chk("evict", row, evict_o, v.e_evict);
    chk("count", row, count_o, v.e_cnt);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("lk_valid%0d", c), row, lk_valid_o[c], v.l_v[c]);
      chk($sformatf("lk_hit%0d", c), row, lk_hit_o[c], v.e_hit[c]);
      chk($sformatf("lk_idx%0d", c), row, lk_idx_o[c], v.e_idx[c]);
      chk($sformatf("lk_ov%0d", c), row, lk_overflow_o[c], v.e_ov[c]);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   k;

    idle();
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    #1;
    chk("rst_count", 0, count_o, 0);
    chk("rst_err", 0, err_o, 0);
    chk("rst_evict", 0, evict_o, 0);
    chk("rst_busy", 0, busy_o, 0);
    chk("rst_lk_valid", 0, lk_valid_o, 0);
    chk("rst_alloc_ready", 0, alloc_ready_o, 1);

    vq.push_back(v_alloc(32'h1000, 32'h10FF, 0, 0, 1));
    vq.push_back(add_lk(add_lk(v_none(1), 0, 32'h10F0, 12'd16, 1, 0, 0), 1, 32'h10F8, 12'd16, 1, 0, 1));
    vq.push_back(v_alloc(32'h2000, 32'h1FFF, 1, 0, 1));
    vq.push_back(v_alloc(32'h1080, 32'h1200, 1, 0, 1));
    vq.push_back(add_lk(add_lk(v_alloc(32'h3000, 32'h30FF, 0, 0, 2), 0, 32'h3000, 12'd1, 0, 0, 0),
                        1, 32'h1000, 12'd0, 1, 0, 0));
    vq.push_back(add_lk(add_lk(v_none(2), 0, 32'h3010, 12'd4, 1, 1, 0), 1, 32'h2FFF, 12'd1, 0, 0, 0));
    vq.push_back(v_alloc(32'hFFFF_FF00, 32'hFFFF_FFFF, 0, 0, 3));
    vq.push_back(add_lk(add_lk(v_none(3), 0, 32'hFFFF_FFF0, 12'h20, 1, 2, 1), 1, 32'hFFFF_FFF0, 12'd0, 1, 2, 0));
    v = v_free(32'h1000, 2);
    v.a_v = 1; v.a_base = 32'h5000; v.a_last = 32'h50FF;
    vq.push_back(v);
    vq.push_back(add_lk(v_alloc(32'h4000, 32'h40FF, 0, 0, 3), 0, 32'h1000, 12'd1, 0, 0, 0));
    vq.push_back(v_free(32'h9999, 3));
    vq.push_back(v_alloc(32'h6000, 32'h60FF, 0, 0, 4));
    vq.push_back(v_alloc(32'h7000, 32'h70FF, 0, 0, 5));
    vq.push_back(v_alloc(32'h8000, 32'h80FF, 0, 0, 6));
    vq.push_back(v_alloc(32'h9000, 32'h90FF, 0, 0, 7));
    vq.push_back(v_alloc(32'h1000, 32'h10FF, 0, 0, 8));
    vq.push_back(v_alloc(32'hA000, 32'hA0FF, 0, 1, 8));
    vq.push_back(add_lk(add_lk(v_none(8), 0, 32'h3000, 12'd1, 0, 0, 0), 1, 32'hA010, 12'h10, 1, 1, 0));
    vq.push_back(add_lk(add_lk(v_none(8), 0, 32'h9000, 12'h100, 1, 7, 0), 1, 32'h1000, 12'h101, 1, 0, 1));
    vq.push_back(v_alloc(32'hB000, 32'hB0FF, 0, 1, 8));
    vq.push_back(add_lk(add_lk(v_none(8), 0, 32'hFFFF_FFF0, 12'd1, 0, 0, 0), 1, 32'hB000, 12'd1, 1, 2, 0));

    for (int r = 0; r < vq.size(); r++) apply(vq[r], r + 1);

    // Clear sweep on a full table, with a lookup part-way through.
    clear_i = 1;
    step();
    k = int'(busy_o);
    clear_i = 0;
    step();
    k += int'(busy_o);
    lk_valid_i = 2'b11;
    lk_addr_i[0] = 32'h1000; lk_len_i[0] = 12'd1;
    lk_addr_i[1] = 32'h9000; lk_len_i[1] = 12'd1;
    step();
    k += int'(busy_o);
    chk("sweep_hit0", 100, lk_hit_o[0], 0);
    chk("sweep_hit1", 100, lk_hit_o[1], 1);
    chk("sweep_idx1", 100, lk_idx_o[1], 7);
    idle();
    for (int c = 0; c < 40 && busy_o; c++) begin
      step();
      k += int'(busy_o);
    end
    chk("busy_cycles", 100, k, 8);
    chk("clear_busy", 100, busy_o, 0);
    chk("clear_count", 100, count_o, 0);

    apply(v_alloc(32'h1000, 32'h10FF, 0, 0, 1), 101);
    apply(add_lk(v_none(1), 0, 32'h1000, 12'd1, 1, 0, 0), 102);
    for (int r = 0; r < 5; r++)
      apply(v_alloc(32'h2000 + 32'(r) * 32'h1000, 32'h20FF + 32'(r) * 32'h1000, 0, 0, r + 2), 103 + r);

    // Asynchronous reset in the third cycle of a sweep.
    clear_i = 1;
    step();
    clear_i = 0;
    step();
    step();
    chk("midsweep_busy", 110, busy_o, 1);
    rst_ni = 0;
    #2;
    chk("arst_busy", 110, busy_o, 0);
    chk("arst_count", 110, count_o, 0);
    chk("arst_lk_valid", 110, lk_valid_o, 0);
    rst_ni = 1;
    #1;
    chk("arst_alloc_ready", 110, alloc_ready_o, 1);
    apply(add_lk(add_lk(v_none(0), 0, 32'h6000, 12'd1, 0, 0, 0), 1, 32'h4000, 12'd1, 0, 0, 0), 111);
    apply(v_alloc(32'h7000, 32'h70FF, 0, 0, 1), 112);
    apply(add_lk(v_none(1), 0, 32'h7080, 12'h100, 1, 0, 1), 113);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
